// File: rtl/barcode_entry_ctrl_pkg.sv
// Shared types and constants for the barcode entry controller.
//   state_t   : entry FSM state (EMPTY / ENTRY / COMPLETE)
//   SEG_BLANK : active-low 7-seg pattern with every segment off
//   SEG_ZERO  : active-low 7-seg pattern showing '0'
package barcode_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        ENTRY    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/barcode_entry_ctrl_if.sv
// Bus between the terminal state machine / basket logic (master) and the
// barcode entry controller (slave).
//   ENABLE, Digit_in, BACKSPACE, CLEAR, ACCEPT : master -> slave strobes
//   Barcode_Digits, NumDigitsEntered, BarcodeCompleted, DigitRejected,
//   TimeoutPulse, HEX_out, dbg_state            : slave -> master
//
// Handshake: there is no ready signal. Each strobe is a single-cycle
// request that the controller always samples on the next rising clock
// edge, and its effect is visible on the outputs one cycle later.
// BarcodeCompleted is a level that stays high until the master pulses
// ACCEPT (or CLEAR/BACKSPACE). DigitRejected and TimeoutPulse are
// single-cycle pulses. When several strobes coincide, CLEAR wins over
// ACCEPT, ACCEPT over BACKSPACE, and BACKSPACE over ENABLE.
interface barcode_entry_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    import barcode_entry_ctrl_pkg::*;

    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic                          ENABLE;
    logic [DIGIT_W-1:0]            Digit_in;
    logic                          BACKSPACE;
    logic                          CLEAR;
    logic                          ACCEPT;
    logic [NUM_DIGITS*DIGIT_W-1:0] Barcode_Digits;
    logic [CW-1:0]                 NumDigitsEntered;
    logic                          BarcodeCompleted;
    logic                          DigitRejected;
    logic                          TimeoutPulse;
    logic [NUM_DIGITS*7-1:0]       HEX_out;
    state_t                        dbg_state;

    modport master (
        output ENABLE, Digit_in, BACKSPACE, CLEAR, ACCEPT,
        input  Barcode_Digits, NumDigitsEntered, BarcodeCompleted,
               DigitRejected, TimeoutPulse, HEX_out, dbg_state
    );

    modport slave (
        input  ENABLE, Digit_in, BACKSPACE, CLEAR, ACCEPT,
        output Barcode_Digits, NumDigitsEntered, BarcodeCompleted,
               DigitRejected, TimeoutPulse, HEX_out, dbg_state
    );

endinterface

// File: rtl/barcode_entry_ctrl_hex7seg.sv
// hex7seg_decoder: combinational 4-bit value to active-low 7-segment
// pattern (bit order gfedcba). Values 10..15 show A, b, C, d, E, F.
//   digit : value to display
//   seg   : active-low segment pattern
module hex7seg_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/barcode_entry_ctrl.sv
// barcode_entry_ctrl: collects NUM_DIGITS decimal digits from single-cycle
// strobes, supports backspace / clear / idle timeout, and holds a completion
// flag until the consumer acknowledges it. Drives one 7-seg pattern per slot.
//   CLOCK_50 : system clock
//   RESET_N  : synchronous, active-low reset
//   bus      : slave side of barcode_entry_ctrl_if (strobes in, digits,
//              count, completion level, reject/timeout pulses, HEX out,
//              FSM state for debug)
// Slot 0 always holds the newest digit; entering a digit shifts older ones up.
module barcode_entry_ctrl
    import barcode_entry_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_DIGIT      = 9,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int BLANK_EMPTY    = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    barcode_entry_ctrl_if.slave  bus
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    // Keep the idle counter at least 1 bit wide when the timeout is disabled.
    localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam bit                 TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [6:0]         SEG_EMPTY = (BLANK_EMPTY != 0) ? SEG_BLANK : SEG_ZERO;
    localparam logic [CW-1:0]      FULL      = CW'(NUM_DIGITS);
    localparam logic [CW-1:0]      CNT_ONE   = 1;
    localparam logic [IW-1:0]      IDLE_ONE  = 1;
    localparam logic [IW-1:0]      IDLE_LAST = TO_EN ? IW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [DIGIT_W-1:0] MAX_D     = DIGIT_W'(MAX_DIGIT);

    state_t                  state_q;
    logic [DIGIT_W-1:0]      slot_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]      slot_d [NUM_DIGITS];
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic [IW-1:0]           idle_q;
    logic                    rejected_q;
    logic                    timeout_q;
    logic [NUM_DIGITS*7-1:0] hex_d;
    logic [NUM_DIGITS*7-1:0] hex_q;

    // Command decode. A higher-priority strobe masks every lower one,
    // even when the higher one turns out to be a no-op in this state.
    logic sel_back;
    logic sel_enable;
    logic digit_ok;
    logic do_clear;
    logic do_accept;
    logic do_back;
    logic do_enable;
    logic do_reject;
    logic do_timeout;

    always_comb begin
        sel_back   = bus.BACKSPACE & ~bus.CLEAR & ~bus.ACCEPT;
        sel_enable = bus.ENABLE & ~bus.CLEAR & ~bus.ACCEPT & ~bus.BACKSPACE;
        digit_ok   = (bus.Digit_in <= MAX_D);
        do_clear   = bus.CLEAR;
        do_accept  = bus.ACCEPT & ~bus.CLEAR & (state_q == COMPLETE);
        do_back    = sel_back & (count_q != '0);
        do_enable  = sel_enable & digit_ok & (count_q != FULL);
        do_reject  = sel_enable & ~(digit_ok & (count_q != FULL));
        // The idle counter only expires on a cycle where nothing was entered or removed.
        do_timeout = TO_EN & (state_q == ENTRY) & (idle_q == IDLE_LAST)
                   & ~(do_clear | do_accept | do_back | do_enable);
    end

    // Next slot contents and count; registered together with the HEX
    // patterns so every output changes on the same edge.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) slot_d[k] = slot_q[k];
        count_d = count_q;
        if (do_clear | do_accept | do_timeout) begin
            for (int k = 0; k < NUM_DIGITS; k++) slot_d[k] = '0;
            count_d = '0;
        end else if (do_back) begin
            for (int k = 0; k < NUM_DIGITS - 1; k++) slot_d[k] = slot_q[k + 1];
            slot_d[NUM_DIGITS - 1] = '0;
            count_d = count_q - CNT_ONE;
        end else if (do_enable) begin
            for (int k = 1; k < NUM_DIGITS; k++) slot_d[k] = slot_q[k - 1];
            slot_d[0] = bus.Digit_in;
            count_d = count_q + CNT_ONE;
        end
    end

    // The decoder takes the low nibble of each slot; wider digits beyond
    // F are not displayable anyway.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slot
        logic [6:0] seg;
        hex7seg_decoder u_dec (
            .digit (4'(slot_d[k])),
            .seg   (seg)
        );
        assign hex_d[k*7 +: 7] = (CW'(k) < count_d) ? seg : SEG_EMPTY;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= EMPTY;
            for (int k = 0; k < NUM_DIGITS; k++) slot_q[k] <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            rejected_q <= 1'b0;
            timeout_q  <= 1'b0;
            hex_q      <= {NUM_DIGITS{SEG_EMPTY}};
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) slot_q[k] <= slot_d[k];
            count_q    <= count_d;
            hex_q      <= hex_d;
            rejected_q <= do_reject;
            timeout_q  <= do_timeout;
            if (do_clear | do_accept | do_timeout) begin
                state_q <= EMPTY;
                idle_q  <= '0;
            end else if (do_back) begin
                state_q <= (count_q == CNT_ONE) ? EMPTY : ENTRY;
                idle_q  <= '0;
            end else if (do_enable) begin
                state_q <= (count_q == FULL - CNT_ONE) ? COMPLETE : ENTRY;
                idle_q  <= '0;
            end else if (TO_EN && state_q == ENTRY) begin
                idle_q <= idle_q + IDLE_ONE;
            end else begin
                idle_q <= '0;
            end
        end
    end

    always_comb begin
        bus.Barcode_Digits = '0;
        for (int k = 0; k < NUM_DIGITS; k++) bus.Barcode_Digits[k*DIGIT_W +: DIGIT_W] = slot_q[k];
    end

    assign bus.NumDigitsEntered = count_q;
    assign bus.BarcodeCompleted = (state_q == COMPLETE);
    assign bus.DigitRejected    = rejected_q;
    assign bus.TimeoutPulse     = timeout_q;
    assign bus.HEX_out          = hex_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_barcode_entry_ctrl.sv
// Bench for barcode_entry_ctrl. Two instances share the same stimulus:
//   dut_a : 4 digits, 10-cycle idle timeout, blank unused positions
//   dut_b : 6 digits, no timeout, unused positions show '0'
// Each instance has a behavioural model (digits kept as an entry-order
// stack) that is compared against the outputs after every clock edge.
module tb_barcode_entry_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    barcode_entry_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(4)) ifa ();
    barcode_entry_ctrl_if #(.NUM_DIGITS(6), .DIGIT_W(4)) ifb ();

    barcode_entry_ctrl #(
        .NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9), .TIMEOUT_CYCLES(10), .BLANK_EMPTY(1)
    ) dut_a (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (ifa)
    );

    barcode_entry_ctrl #(
        .NUM_DIGITS(6), .DIGIT_W(4), .MAX_DIGIT(9), .TIMEOUT_CYCLES(0), .BLANK_EMPTY(0)
    ) dut_b (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (ifb)
    );

    int checks = 0;
    int failures = 0;

    // Model configuration and state, index 0 = dut_a, 1 = dut_b.
    int         m_n [2] = '{4, 6};
    int         m_t [2] = '{10, 0};
    logic [6:0] m_empty_seg [2] = '{7'h7F, 7'h40};
    int         m_cnt [2] = '{0, 0};
    int         m_idle [2] = '{0, 0};
    logic [3:0] m_seq [2][8];
    bit         m_rej [2] = '{0, 0};
    bit         m_to [2] = '{0, 0};

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Apply one sampled cycle of stimulus to model i.
    task automatic model_apply(input int i, input bit en, input logic [3:0] d,
                               input bit bs, input bit clr, input bit acc);
        bit changed;
        changed = 0;
        m_rej[i] = 0;
        m_to[i] = 0;
        if (!rst_n) begin
            m_cnt[i] = 0;
            m_idle[i] = 0;
            return;
        end
        if (clr) begin
            m_cnt[i] = 0;
            changed = 1;
        end else if (acc) begin
            if (m_cnt[i] == m_n[i]) begin
                m_cnt[i] = 0;
                changed = 1;
            end
        end else if (bs) begin
            if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                changed = 1;
            end
        end else if (en) begin
            if (d <= 4'd9 && m_cnt[i] < m_n[i]) begin
                m_seq[i][m_cnt[i]] = d;
                m_cnt[i] = m_cnt[i] + 1;
                changed = 1;
            end else begin
                m_rej[i] = 1;
            end
        end
        if (changed || m_cnt[i] == 0 || m_cnt[i] == m_n[i]) begin
            m_idle[i] = 0;
        end else if (m_t[i] > 0) begin
            m_idle[i] = m_idle[i] + 1;
            if (m_idle[i] == m_t[i]) begin
                m_cnt[i] = 0;
                m_idle[i] = 0;
                m_to[i] = 1;
            end
        end
    endtask

    function automatic logic [63:0] exp_digits(input int i);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < m_n[i]; k++)
            if (k < m_cnt[i]) v[k*4 +: 4] = m_seq[i][m_cnt[i] - 1 - k];
        return v;
    endfunction

    function automatic logic [63:0] exp_hex(input int i);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < m_n[i]; k++)
            v[k*7 +: 7] = (k < m_cnt[i]) ? seg_tab[m_seq[i][m_cnt[i] - 1 - k]] : m_empty_seg[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_digits", 64'(ifa.Barcode_Digits), exp_digits(0));
        check("a_hex", 64'(ifa.HEX_out), exp_hex(0));
        check("a_count", 64'(ifa.NumDigitsEntered), 64'(m_cnt[0]));
        check("a_completed", 64'(ifa.BarcodeCompleted), 64'(m_cnt[0] == m_n[0]));
        check("a_rejected", 64'(ifa.DigitRejected), 64'(m_rej[0]));
        check("a_timeout", 64'(ifa.TimeoutPulse), 64'(m_to[0]));
        check("b_digits", 64'(ifb.Barcode_Digits), exp_digits(1));
        check("b_hex", 64'(ifb.HEX_out), exp_hex(1));
        check("b_count", 64'(ifb.NumDigitsEntered), 64'(m_cnt[1]));
        check("b_completed", 64'(ifb.BarcodeCompleted), 64'(m_cnt[1] == m_n[1]));
        check("b_rejected", 64'(ifb.DigitRejected), 64'(m_rej[1]));
        check("b_timeout", 64'(ifb.TimeoutPulse), 64'(m_to[1]));
    endtask

    // One clock cycle: drive strobes, let the edge sample them, update the
    // models, then compare shortly after the edge.
    task automatic step(input bit en, input logic [3:0] d, input bit bs,
                        input bit clr, input bit acc);
        ifa.ENABLE = en; ifa.Digit_in = d; ifa.BACKSPACE = bs; ifa.CLEAR = clr; ifa.ACCEPT = acc;
        ifb.ENABLE = en; ifb.Digit_in = d; ifb.BACKSPACE = bs; ifb.CLEAR = clr; ifb.ACCEPT = acc;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_apply(i, en, d, bs, clr, acc);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_clear();
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic press_accept();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press_back();
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Clock/reset
        rst_n = 1'b0;
        idle();
        idle();
        check("rst_a_hex_lit", 64'(ifa.HEX_out), 64'({4{7'h7F}}));
        check("rst_b_hex_lit", 64'(ifb.HEX_out), 64'({6{7'h40}}));
        check("rst_a_count_lit", 64'(ifa.NumDigitsEntered), 64'd0);
        rst_n = 1'b1;
        idle();

        // Enter 1,2,3,4
        enter(4'd1); enter(4'd2); enter(4'd3);
        check("t1_a_not_done_lit", 64'(ifa.BarcodeCompleted), 64'd0);
        enter(4'd4);
        check("t1_a_digits_lit", 64'(ifa.Barcode_Digits), 64'h1234);
        check("t1_a_count_lit", 64'(ifa.NumDigitsEntered), 64'd4);
        check("t1_a_done_lit", 64'(ifa.BarcodeCompleted), 64'd1);
        check("t1_a_hex_lit", 64'(ifa.HEX_out), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

        // Digit while complete is rejected; ACCEPT releases
        enter(4'd5);
        check("t2_a_rej_lit", 64'(ifa.DigitRejected), 64'd1);
        check("t2_a_digits_lit", 64'(ifa.Barcode_Digits), 64'h1234);
        check("t2_b_count_lit", 64'(ifb.NumDigitsEntered), 64'd5);
        idle();
        check("t2_a_rej_gone_lit", 64'(ifa.DigitRejected), 64'd0);
        press_accept();
        check("t2_a_acc_count_lit", 64'(ifa.NumDigitsEntered), 64'd0);
        check("t2_a_acc_done_lit", 64'(ifa.BarcodeCompleted), 64'd0);
        check("t2_b_acc_ignored_lit", 64'(ifb.NumDigitsEntered), 64'd5);
        press_clear();

        // Backspace and out-of-range digit
        enter(4'd7); enter(4'd8); press_back();
        check("t3_a_count_lit", 64'(ifa.NumDigitsEntered), 64'd1);
        check("t3_a_digits_lit", 64'(ifa.Barcode_Digits), 64'h0007);
        check("t3_a_hex_lit", 64'(ifa.HEX_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h78}));
        enter(4'd12);
        check("t3_a_rej_lit", 64'(ifa.DigitRejected), 64'd1);
        check("t3_b_rej_lit", 64'(ifb.DigitRejected), 64'd1);
        check("t3_a_count_kept_lit", 64'(ifa.NumDigitsEntered), 64'd1);
        press_back();
        press_back();
        check("t3_a_bs_empty_lit", 64'(ifa.DigitRejected), 64'd0);

        // CLEAR beats ENABLE in the same cycle
        enter(4'd9); enter(4'd2);
        step(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        check("t4_a_count_lit", 64'(ifa.NumDigitsEntered), 64'd0);
        check("t4_a_rej_lit", 64'(ifa.DigitRejected), 64'd0);
        check("t4_b_count_lit", 64'(ifb.NumDigitsEntered), 64'd0);

        // Idle timeout in ENTRY, none in COMPLETE
        enter(4'd1);
        repeat (9) idle();
        check("t5_a_no_to_yet_lit", 64'(ifa.TimeoutPulse), 64'd0);
        check("t5_a_count_held_lit", 64'(ifa.NumDigitsEntered), 64'd1);
        idle();
        check("t5_a_to_lit", 64'(ifa.TimeoutPulse), 64'd1);
        check("t5_a_to_count_lit", 64'(ifa.NumDigitsEntered), 64'd0);
        check("t5_b_no_to_lit", 64'(ifb.NumDigitsEntered), 64'd1);
        idle();
        check("t5_a_to_gone_lit", 64'(ifa.TimeoutPulse), 64'd0);
        press_clear();
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4);
        repeat (15) idle();
        check("t5_a_complete_held_lit", 64'(ifa.BarcodeCompleted), 64'd1);
        check("t5_a_complete_count_lit", 64'(ifa.NumDigitsEntered), 64'd4);
        press_accept();
        press_clear();

        // Reset mid-entry, then full 6-digit entry on dut_b
        enter(4'd4); enter(4'd5); enter(4'd6);
        check("t6_a_pre_count_lit", 64'(ifa.NumDigitsEntered), 64'd3);
        rst_n = 1'b0;
        idle();
        check("t6_a_rst_count_lit", 64'(ifa.NumDigitsEntered), 64'd0);
        check("t6_a_rst_digits_lit", 64'(ifa.Barcode_Digits), 64'd0);
        check("t6_a_rst_hex_lit", 64'(ifa.HEX_out), 64'({4{7'h7F}}));
        check("t6_b_rst_hex_lit", 64'(ifb.HEX_out), 64'({6{7'h40}}));
        rst_n = 1'b1;
        idle();
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4); enter(4'd5); enter(4'd6);
        check("t6_b_digits_lit", 64'(ifb.Barcode_Digits), 64'h123456);
        check("t6_b_done_lit", 64'(ifb.BarcodeCompleted), 64'd1);
        check("t6_b_count_lit", 64'(ifb.NumDigitsEntered), 64'd6);
        check("t6_b_hex_lit", 64'(ifb.HEX_out),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
